// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, reset PC, fetch FSM states and redirect target select.
package fetch_ctrl_pkg;
  localparam int XLEN = 64;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_e;
  // Trap beats branch; targets are forced word-aligned.
  function automatic logic [XLEN-1:0] redirect_target(
    input logic            trap_valid,
    input logic [XLEN-1:0] trap_pc,
    input logic [XLEN-1:0] redirect_pc
  );
    return {(trap_valid ? trap_pc[XLEN-1:2] : redirect_pc[XLEN-1:2]), 2'b00};
  endfunction
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry fetched-instruction buffer with load, consume and flush.
module fetch_buf
  import fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              consume_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o
);
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  always_comb begin
    valid_d = load_i ? 1'b1 : (consume_i | flush_i) ? 1'b0 : valid_q;
    pc_d    = load_i ? pc_i : pc_q;
    inst_d  = load_i ? inst_i : inst_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end
  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencer driving the imem handshake and a one-entry decode buffer.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  input  logic              trap_valid_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  output logic              imem_req_valid_o,
  output logic [XLEN-1:0]   imem_req_addr_o,
  input  logic              imem_req_ready_i,
  input  logic              imem_resp_valid_i,
  input  logic [INST_W-1:0] imem_resp_inst_i,
  output logic              id_valid_o,
  output logic [XLEN-1:0]   id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  input  logic              id_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [63:0]       fetch_cnt_o
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [63:0]     cnt_q, cnt_d;
  logic            redir, load, consume, flush;
  logic [XLEN-1:0] tgt;
  assign redir = redirect_valid_i | trap_valid_i;
  assign tgt   = redirect_target(trap_valid_i, trap_pc_i, redirect_pc_i);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    consume = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem_req_ready_i) state_d = redir ? DROP : WAIT;
      WAIT: begin
        if (imem_resp_valid_i) begin
          state_d = redir ? REQ : HOLD;
          load    = !redir;
          pc_d    = pc_q + XLEN'(4);
        end else if (redir) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        if (redir) begin
          flush   = 1'b1;
          state_d = REQ;
        end else if (id_ready_i) begin
          consume = 1'b1;
          cnt_d   = cnt_q + 64'd1;
          state_d = REQ;
        end
      end
      DROP: if (imem_resp_valid_i) state_d = REQ;
      default: state_d = IDLE;
    endcase
    // A redirect always owns the next PC, even over the sequential increment.
    if (redir) pc_d = tgt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end
  fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .consume_i (consume),
    .flush_i   (flush),
    .pc_i      (pc_q),
    .inst_i    (imem_resp_inst_i),
    .valid_o   (id_valid_o),
    .pc_o      (id_pc_o),
    .inst_o    (id_inst_o)
  );
  assign imem_req_valid_o = state_q == REQ;
  assign imem_req_addr_o  = pc_q;
  assign pc_o             = pc_q;
  assign fetch_cnt_o      = cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench; stimulus queues expected requests/deliveries, a monitor checks them.
module tb_fetch_ctrl;
  logic        clk, rst;
  logic        redirect_valid_i, trap_valid_i;
  logic [63:0] redirect_pc_i, trap_pc_i;
  logic        imem_req_valid_o, imem_req_ready_i, imem_resp_valid_i;
  logic [63:0] imem_req_addr_o;
  logic [31:0] imem_resp_inst_i;
  logic        id_valid_o, id_ready_i;
  logic [63:0] id_pc_o, pc_o, fetch_cnt_o;
  logic [31:0] id_inst_o;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    int          lat;
  } id_t;
  logic [63:0] exp_req[$];
  id_t         exp_id[$];
  id_t         e;
  logic [63:0] ea;
  int checks = 0, failures = 0;
  int cyc = 0, last_fire = 0, lat = 1, pend = 0;
  logic        fire_s, rst_s;
  logic [63:0] faddr, paddr;
  fetch_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_pc_i     (redirect_pc_i),
    .trap_valid_i      (trap_valid_i),
    .trap_pc_i         (trap_pc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_inst_i  (imem_resp_inst_i),
    .id_valid_o        (id_valid_o),
    .id_pc_o           (id_pc_o),
    .id_inst_o         (id_inst_o),
    .id_ready_i        (id_ready_i),
    .pc_o              (pc_o),
    .fetch_cnt_o       (fetch_cnt_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] f(input logic [63:0] pc);
    return pc[31:0] ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, x);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_fetch(input logic [63:0] pc, input int l, input bit deliver);
    id_t t;
    exp_req.push_back(pc);
    t.pc = pc;
    t.inst = f(pc);
    t.lat = l;
    if (deliver) exp_id.push_back(t);
  endtask
  task automatic wait_cnt(input logic [63:0] n);
    for (int i = 0; i < 100; i++) begin
      step();
      if (fetch_cnt_o == n) return;
    end
    chk("wait_cnt_timeout", fetch_cnt_o, n);
  endtask
  task automatic wait_idv();
    for (int i = 0; i < 100; i++) begin
      step();
      if (id_valid_o) return;
    end
    chk("wait_idv_timeout", {63'd0, id_valid_o}, 64'd1);
  endtask
  task automatic wait_reqv();
    for (int i = 0; i < 100; i++) begin
      step();
      if (imem_req_valid_o) return;
    end
    chk("wait_reqv_timeout", {63'd0, imem_req_valid_o}, 64'd1);
  endtask
  task automatic redirect1(input bit br, input logic [63:0] bpc, input bit tr, input logic [63:0] tpc);
    redirect_valid_i = br;
    redirect_pc_i = bpc;
    trap_valid_i = tr;
    trap_pc_i = tpc;
    step();
    redirect_valid_i = 1'b0;
    trap_valid_i = 1'b0;
  endtask
  // imem model: in-order, one response lat cycles after each accepted request.
  initial begin
    imem_resp_valid_i = 1'b0;
    imem_resp_inst_i = '0;
    forever begin
      @(negedge clk);
      fire_s = imem_req_valid_o && imem_req_ready_i;
      faddr = imem_req_addr_o;
      rst_s = rst;
      @(posedge clk);
      #1;
      imem_resp_valid_i = 1'b0;
      if (rst_s) pend = 0;
      else begin
        if (fire_s) begin
          pend = lat;
          paddr = faddr;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            imem_resp_valid_i = 1'b1;
            imem_resp_inst_i = f(paddr);
          end
        end
      end
    end
  end
  // Monitor: a HOLD-cycle redirect means the handshake is not a delivery.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req_valid_o && imem_req_ready_i) begin
        last_fire = cyc;
        if (exp_req.size() == 0) chk("req_unexpected", imem_req_addr_o, 64'd0 - 64'd1);
        else begin
          ea = exp_req.pop_front();
          chk("req_addr", imem_req_addr_o, ea);
        end
      end
      if (id_valid_o && id_ready_i && !redirect_valid_i && !trap_valid_i) begin
        if (exp_id.size() == 0) chk("id_unexpected", id_pc_o, 64'd0 - 64'd1);
        else begin
          e = exp_id.pop_front();
          chk("id_pc", id_pc_o, e.pc);
          chk("id_inst", {32'd0, id_inst_o}, {32'd0, e.inst});
          if (e.lat >= 0) chk("id_latency", 64'(cyc - last_fire), 64'(e.lat));
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    redirect_valid_i = 1'b0;
    trap_valid_i = 1'b0;
    redirect_pc_i = '0;
    trap_pc_i = '0;
    imem_req_ready_i = 1'b0;
    id_ready_i = 1'b1;
    step();
    step();
    chk("rst_pc", pc_o, 64'h8000_0000);
    chk("rst_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
    chk("rst_id_valid", {63'd0, id_valid_o}, 64'd0);
    chk("rst_id_pc", id_pc_o, 64'd0);
    chk("rst_id_inst", {32'd0, id_inst_o}, 64'd0);
    chk("rst_cnt", fetch_cnt_o, 64'd0);
    // Streaming fetch, k=1, decode always ready.
    expect_fetch(64'h8000_0000, 2, 1);
    expect_fetch(64'h8000_0004, 2, 1);
    expect_fetch(64'h8000_0008, 2, 1);
    imem_req_ready_i = 1'b1;
    rst = 1'b0;
    wait_cnt(64'd3);
    imem_req_ready_i = 1'b0;
    chk("stream_cnt", fetch_cnt_o, 64'd3);
    // Decode back-pressure in HOLD.
    id_ready_i = 1'b0;
    expect_fetch(64'h8000_000C, -1, 1);
    imem_req_ready_i = 1'b1;
    wait_idv();
    imem_req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", {63'd0, id_valid_o}, 64'd1);
      chk("hold_pc", id_pc_o, 64'h8000_000C);
      chk("hold_inst", {32'd0, id_inst_o}, {32'd0, f(64'h8000_000C)});
      chk("hold_noreq", {63'd0, imem_req_valid_o}, 64'd0);
      chk("hold_pc_o", pc_o, 64'h8000_0010);
    end
    id_ready_i = 1'b1;
    wait_cnt(64'd4);
    // Redirect while waiting; stale response lands in DROP.
    lat = 3;
    expect_fetch(64'h8000_0010, -1, 0);
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    redirect1(1'b1, 64'h8000_0100, 1'b0, 64'd0);
    chk("wait_redir_pc", pc_o, 64'h8000_0100);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drop_no_id", {63'd0, id_valid_o}, 64'd0);
    end
    chk("drop_req_valid", {63'd0, imem_req_valid_o}, 64'd1);
    chk("drop_req_addr", imem_req_addr_o, 64'h8000_0100);
    chk("drop_cnt", fetch_cnt_o, 64'd4);
    lat = 1;
    expect_fetch(64'h8000_0100, 2, 1);
    imem_req_ready_i = 1'b1;
    wait_cnt(64'd5);
    imem_req_ready_i = 1'b0;
    // Trap and branch together while REQ is stalled: trap wins.
    redirect1(1'b1, 64'h8000_0100, 1'b1, 64'h8000_0800);
    chk("prio_pc", pc_o, 64'h8000_0800);
    chk("prio_req_addr", imem_req_addr_o, 64'h8000_0800);
    chk("prio_req_valid", {63'd0, imem_req_valid_o}, 64'd1);
    expect_fetch(64'h8000_0800, 2, 1);
    imem_req_ready_i = 1'b1;
    wait_cnt(64'd6);
    imem_req_ready_i = 1'b0;
    // Redirect in HOLD with id_ready the same cycle: flushed, not counted.
    expect_fetch(64'h8000_0804, -1, 0);
    id_ready_i = 1'b0;
    imem_req_ready_i = 1'b1;
    wait_idv();
    imem_req_ready_i = 1'b0;
    id_ready_i = 1'b1;
    redirect1(1'b1, 64'h8000_0102, 1'b0, 64'd0);
    chk("flush_valid", {63'd0, id_valid_o}, 64'd0);
    chk("flush_cnt", fetch_cnt_o, 64'd6);
    chk("flush_align_pc", pc_o, 64'h8000_0100);
    expect_fetch(64'h8000_0100, 2, 1);
    imem_req_ready_i = 1'b1;
    wait_cnt(64'd7);
    imem_req_ready_i = 1'b0;
    // Redirect in REQ as the old request is accepted.
    lat = 2;
    expect_fetch(64'h8000_0104, -1, 0);
    imem_req_ready_i = 1'b1;
    redirect1(1'b1, 64'h8000_0200, 1'b0, 64'd0);
    imem_req_ready_i = 1'b0;
    chk("reqredir_pc", pc_o, 64'h8000_0200);
    chk("reqredir_noreq", {63'd0, imem_req_valid_o}, 64'd0);
    wait_reqv();
    chk("reqredir_addr", imem_req_addr_o, 64'h8000_0200);
    chk("reqredir_cnt", fetch_cnt_o, 64'd7);
    chk("reqredir_noid", {63'd0, id_valid_o}, 64'd0);
    lat = 1;
    expect_fetch(64'h8000_0200, 2, 1);
    imem_req_ready_i = 1'b1;
    wait_cnt(64'd8);
    imem_req_ready_i = 1'b0;
    // PC wrap at the top of the address space.
    redirect1(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0);
    expect_fetch(64'hFFFF_FFFF_FFFF_FFFC, 2, 1);
    imem_req_ready_i = 1'b1;
    wait_cnt(64'd9);
    imem_req_ready_i = 1'b0;
    chk("wrap_pc", pc_o, 64'd0);
    chk("wrap_addr", imem_req_addr_o, 64'd0);
    // Reset while in DROP.
    lat = 3;
    expect_fetch(64'd0, -1, 0);
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    redirect1(1'b1, 64'h8000_0300, 1'b0, 64'd0);
    chk("pre_rst_pc", pc_o, 64'h8000_0300);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_pc", pc_o, 64'h8000_0000);
    chk("mid_rst_req", {63'd0, imem_req_valid_o}, 64'd0);
    chk("mid_rst_idv", {63'd0, id_valid_o}, 64'd0);
    chk("mid_rst_cnt", fetch_cnt_o, 64'd0);
    lat = 1;
    expect_fetch(64'h8000_0000, 2, 1);
    imem_req_ready_i = 1'b1;
    wait_cnt(64'd1);
    imem_req_ready_i = 1'b0;
    step();
    chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
    chk("id_queue_empty", 64'(exp_id.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
